// File: rtl/memwb_skid.sv
// MEM/WB pipeline register with a two-entry skid buffer. The head entry drives
// the WB stage and the forwarding path; the skid entry absorbs one extra beat.
module memwb_skid #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [RA_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_mem,
  output logic [RA_W-1:0]   out_rd,
  output logic              fwd_en,
  output logic [RA_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [RA_W-1:0]   rd;
  } beat_t;

  state_t state_reg;
  beat_t  head_reg;
  beat_t  skid_reg;
  beat_t  in_beat;
  logic   in_ready_reg;
  logic   accept;
  logic   drain;

  assign in_beat = '{wb: in_wb, alu: in_alu, mem: in_mem, rd: in_rd};
  assign accept  = in_valid && in_ready_reg;
  assign drain   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      head_reg     <= '0;
      skid_reg     <= '0;
    end else if (flush) begin
      // Data fields are left alone so out_alu/out_mem/out_rd keep their last values.
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_reg  <= in_beat;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_reg     <= in_beat;
            state_reg    <= FULL;
            in_ready_reg <= 1'b0;
          end else if (accept && drain) begin
            head_reg <= in_beat;
          end else if (drain) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            head_reg     <= skid_reg;
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign occ       = state_reg;
  assign out_valid = (state_reg != EMPTY);
  // Control is gated so an empty stage can never issue a stray RegWrite.
  assign out_wb    = out_valid ? head_reg.wb : '0;
  assign out_alu   = head_reg.alu;
  assign out_mem   = head_reg.mem;
  assign out_rd    = head_reg.rd;

  assign fwd_en   = out_valid && out_wb[1] && (out_rd != '0);
  assign fwd_rd   = out_rd;
  assign fwd_data = out_wb[0] ? out_mem : out_alu;

endmodule
